nes_controller_reader: RTL and testbench

NES_CONTROLLER_READER -- requirements
Module: nes_controller_reader

---
 rtl/nes_pkg.sv | 41 ++++
 rtl/nes_sync2.sv | 27 ++
 rtl/nes_controller_reader.sv | 163 ++++++++++++++++
 tb/tb_nes_controller_reader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared definitions for the NES controller reader: FSM state encoding,
// counter widths and button bit positions. The CPU-side software header
// mirrors the button positions, so change them in both places together.
package nes_pkg;

   // Reader FSM states. The explicit values match the software header.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LATCH = 3'd1,
      ST_LOW   = 3'd2,
      ST_HIGH  = 3'd3,
      ST_DONE  = 3'd4
   } nes_state_t;

   // Phase counter and bit index widths.
   localparam int CNT_W = 20;
   localparam int IDX_W = 3;

   // Number of buttons shifted out per frame.
   localparam int NUM_BUTTONS = 8;

   // Bit positions in the buttons word, in controller shift order.
   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   // Index of the final bit of a frame.
   localparam logic [IDX_W-1:0] LAST_BIT_IDX = IDX_W'(NUM_BUTTONS - 1);

   // Terminal count for a phase lasting 'cycles' clocks; the phase counter
   // starts at zero, so the last cycle of the phase sees cycles-1.
   function automatic logic [CNT_W-1:0] cycles_to_last(input int cycles);
      return CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/nes_sync2.sv
// Two-flop synchronizer for the controller's serial data line.
// Resets to 1 so that an idle or disconnected line reads as
// "nothing pressed" straight out of reset.
module nes_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_reg;
   logic sync_reg;

   // Shift the asynchronous input through two flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_reg <= 1'b1;
         sync_reg <= 1'b1;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/nes_controller_reader.sv
// NES controller reader. Periodically latches the controller, clocks the
// eight button bits out over its serial line and publishes them as one
// active-high byte with a one-cycle frame_valid strobe.
//
// Frame timing, with D = CLK_DIV:
//   IDLE  POLL_PERIOD cycles
//   LATCH 2*D cycles (nes_latch high)
//   LOW   D cycles per bit, data sampled on the last LOW cycle
//   HIGH  D cycles between bits (nes_clk high), 7 per frame
//   DONE  1 cycle, buttons/frame_valid updated at its end
// So frame_valid arrives 17*D+1 cycles after LATCH entry.
//
// nes_latch and nes_clk are registered from the next state, so both are
// glitch-free and can never be high together.
module nes_controller_reader
   import nes_pkg::*;
#(
   parameter int CLK_DIV     = 300,
   parameter int POLL_PERIOD = 833333
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       nes_data,
   output logic       nes_latch,
   output logic       nes_clk,
   output logic [7:0] buttons,
   output logic       frame_valid
);

   // Terminal counts for each phase.
   localparam logic [CNT_W-1:0] IDLE_LAST  = cycles_to_last(POLL_PERIOD);
   localparam logic [CNT_W-1:0] LATCH_LAST = cycles_to_last(2 * CLK_DIV);
   localparam logic [CNT_W-1:0] HALF_LAST  = cycles_to_last(CLK_DIV);

   logic                   data_sync;

   nes_state_t             state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic [IDX_W-1:0]       idx_reg, idx_next;
   logic [NUM_BUTTONS-1:0] shift_reg, shift_next;
   logic [NUM_BUTTONS-1:0] buttons_reg, buttons_next;
   logic                   frame_valid_reg, frame_valid_next;
   logic                   latch_reg, latch_next;
   logic                   nclk_reg, nclk_next;

   logic [CNT_W-1:0]       phase_last;
   logic                   phase_done;

   // The serial line is asynchronous; nothing looks at it unsynchronized.
   nes_sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (nes_data),
      .q     (data_sync)
   );

   // Pick the terminal count of the phase currently being timed.
   always_comb begin
      phase_last = HALF_LAST;
      case (state_reg)
         ST_IDLE:  phase_last = IDLE_LAST;
         ST_LATCH: phase_last = LATCH_LAST;
         default:  phase_last = HALF_LAST;
      endcase
   end

   assign phase_done = (cnt_reg == phase_last);

   // Next-state, counter, shift and output logic of the frame sequencer.
   always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg + 1'b1;
      idx_next         = idx_reg;
      shift_next       = shift_reg;
      buttons_next     = buttons_reg;
      frame_valid_next = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (phase_done) begin
               state_next = ST_LATCH;
               cnt_next   = '0;
            end
         end

         ST_LATCH: begin
            if (phase_done) begin
               state_next = ST_LOW;
               cnt_next   = '0;
               idx_next   = '0;
            end
         end

         ST_LOW: begin
            if (phase_done) begin
               // The line is active-low: a pressed button drives 0.
               shift_next[idx_reg] = ~data_sync;
               cnt_next            = '0;
               if (idx_reg == LAST_BIT_IDX) begin
                  state_next = ST_DONE;
               end else begin
                  state_next = ST_HIGH;
               end
            end
         end

         ST_HIGH: begin
            if (phase_done) begin
               state_next = ST_LOW;
               cnt_next   = '0;
               idx_next   = idx_reg + 1'b1;
            end
         end

         ST_DONE: begin
            // Publish the whole frame at once; no partial updates.
            buttons_next     = shift_reg;
            frame_valid_next = 1'b1;
            state_next       = ST_IDLE;
            cnt_next         = '0;
         end

         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            idx_next   = '0;
         end
      endcase

      // Controller strobes follow the state being entered.
      latch_next = (state_next == ST_LATCH);
      nclk_next  = (state_next == ST_HIGH);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= ST_IDLE;
         cnt_reg         <= '0;
         idx_reg         <= '0;
         shift_reg       <= '0;
         buttons_reg     <= '0;
         frame_valid_reg <= 1'b0;
         latch_reg       <= 1'b0;
         nclk_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         idx_reg         <= idx_next;
         shift_reg       <= shift_next;
         buttons_reg     <= buttons_next;
         frame_valid_reg <= frame_valid_next;
         latch_reg       <= latch_next;
         nclk_reg        <= nclk_next;
      end
   end

   assign nes_latch   = latch_reg;
   assign nes_clk     = nclk_reg;
   assign buttons     = buttons_reg;
   assign frame_valid = frame_valid_reg;

endmodule

// File: tb/tb_nes_controller_reader.sv
// Self-checking bench for nes_controller_reader. Two instances share one
// clock: one with CLK_DIV=4 driven by a 4021-style shift-register
// controller model, one with CLK_DIV=1 driven by a cycle-timed model that
// presents bit k for the two cycles starting 2*k after latch rise.
// Expected buttons are the pattern the controller held while latched.
module tb_nes_controller_reader;

   localparam int W_LATCH4      = 0;
   localparam int W_LATCH4_FALL = 1;
   localparam int W_FV4         = 2;
   localparam int W_LATCH1      = 3;
   localparam int W_FV1         = 4;

   logic       clk = 1'b0;
   logic       rst4 = 1'b1;
   logic       rst1 = 1'b1;
   logic       nes_data4 = 1'b1;
   logic       nes_data1 = 1'b1;
   logic       nes_latch4, nes_clk4, fv4;
   logic       nes_latch1, nes_clk1, fv1;
   logic [7:0] buttons4, buttons1;

   int vectors     = 0;
   int miscompares = 0;

   // Controller-side stimulus state.
   logic [7:0] pat4   = 8'h00;
   logic [7:0] pat1   = 8'h00;
   logic       force4 = 1'b0;
   logic       lvl4   = 1'b1;

   always #5 clk = ~clk;

   nes_controller_reader #(.CLK_DIV(4), .POLL_PERIOD(20)) dut4 (
      .clk         (clk),
      .reset       (rst4),
      .nes_data    (nes_data4),
      .nes_latch   (nes_latch4),
      .nes_clk     (nes_clk4),
      .buttons     (buttons4),
      .frame_valid (fv4)
   );

   nes_controller_reader #(.CLK_DIV(1), .POLL_PERIOD(20)) dut1 (
      .clk         (clk),
      .reset       (rst1),
      .nes_data    (nes_data1),
      .nes_latch   (nes_latch1),
      .nes_clk     (nes_clk1),
      .buttons     (buttons1),
      .frame_valid (fv1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic probe(input int which);
      case (which)
         W_LATCH4:      return nes_latch4;
         W_LATCH4_FALL: return ~nes_latch4;
         W_FV4:         return fv4;
         W_LATCH1:      return nes_latch1;
         W_FV1:         return fv1;
         default:       return 1'b0;
      endcase
   endfunction

   // Count falling edges until the probed condition holds, bounded.
   task automatic wait_for(input int which, input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (probe(which) !== 1'b1 && n < budget);
      chk($sformatf("wait_bound_%0d", which), 32'(probe(which)), 32'd1);
   endtask

   // 4021-style controller for the CLK_DIV=4 instance.
   logic [7:0] sr4     = 8'h00;
   logic       mclk_p4 = 1'b0;
   always @(negedge clk) begin
      if (nes_latch4 === 1'b1) sr4 = pat4;
      else if (nes_clk4 === 1'b1 && !mclk_p4) sr4 = {1'b0, sr4[7:1]};
      mclk_p4   = (nes_clk4 === 1'b1);
      nes_data4 = force4 ? lvl4 : ~sr4[0];
   end

   // Protocol and result monitor for the CLK_DIV=4 instance.
   int         cyc4, rise4, last_fv4, clkr4, rises4;
   bit         have_fall4, fv_real4;
   logic       lat_p4, nclk_p4;
   logic [7:0] btn_p4, exp4;
   always @(negedge clk) begin
      if (rst4 !== 1'b0) begin
         cyc4 = 0; last_fv4 = 0; fv_real4 = 0; have_fall4 = 0; rises4 = 0;
         rise4 = 0; clkr4 = 0; lat_p4 = 0; nclk_p4 = 0; btn_p4 = 8'h00; exp4 = 8'h00;
      end else begin
         cyc4++;
         chk("latch_and_clk4", 32'(nes_latch4 & nes_clk4), 32'd0);
         if (nes_latch4 && !lat_p4) begin
            rise4 = cyc4;
            chk("idle_len4", cyc4 - last_fv4, 20);
         end
         if (nes_latch4) exp4 = force4 ? (lvl4 ? 8'h00 : 8'hFF) : pat4;
         if (!nes_latch4 && lat_p4) begin
            chk("latch_width4", cyc4 - rise4, 8);
            if (have_fall4) chk("clk_pulses4", rises4, 7);
            have_fall4 = 1;
            rises4     = 0;
         end
         if (nes_clk4 && !nclk_p4) begin
            rises4++;
            clkr4 = cyc4;
         end
         if (!nes_clk4 && nclk_p4) chk("clk_width4", cyc4 - clkr4, 4);
         if (fv4) begin
            chk("frame_len4", cyc4 - rise4, 69);
            if (fv_real4) chk("frame_period4", cyc4 - last_fv4, 89);
            chk("buttons4", 32'(buttons4), 32'(exp4));
            last_fv4 = cyc4;
            fv_real4 = 1;
         end else begin
            chk("buttons_hold4", 32'(buttons4), 32'(btn_p4));
         end
         lat_p4  = nes_latch4;
         nclk_p4 = nes_clk4;
         btn_p4  = buttons4;
      end
   end

   // Cycle-timed controller and monitor for the CLK_DIV=1 instance.
   int         cyc1, rise1, n1, frames1 = 0;
   logic       mlat_p1;
   logic [7:0] snap1;
   logic [2:0] bi1;
   always @(negedge clk) begin
      if (rst1 !== 1'b0) begin
         cyc1 = 0; rise1 = 0; n1 = 64; mlat_p1 = 0; snap1 = 8'h00; nes_data1 = 1'b1;
      end else begin
         cyc1++;
         if (nes_latch1 && !mlat_p1) begin
            n1    = 0;
            snap1 = pat1;
            rise1 = cyc1;
         end else if (n1 < 64) begin
            n1++;
         end
         bi1       = 3'(n1 / 2);
         nes_data1 = (n1 < 16) ? ~snap1[bi1] : 1'b1;
         chk("latch_and_clk1", 32'(nes_latch1 & nes_clk1), 32'd0);
         if (fv1) begin
            chk("frame_len1", cyc1 - rise1, 18);
            chk("buttons1", 32'(buttons1), 32'(snap1));
            frames1++;
         end
         mlat_p1 = nes_latch1;
      end
   end

   initial begin
      int n;

      // Reset values.
      repeat (3) @(negedge clk);
      chk("rst_buttons4", 32'(buttons4), 32'd0);
      chk("rst_latch4", 32'(nes_latch4), 32'd0);
      chk("rst_nclk4", 32'(nes_clk4), 32'd0);
      chk("rst_fv4", 32'(fv4), 32'd0);
      chk("rst_buttons1", 32'(buttons1), 32'd0);

      // CLK_DIV=1: one frame of 8'hA5.
      pat1 = 8'hA5;
      #2 rst1 = 1'b0;
      wait_for(W_LATCH1, 60, n);
      chk("idle_after_rst1", n, 20);
      wait_for(W_FV1, 60, n);
      chk("frame_len_div1", n, 18);
      chk("buttons_div1", 32'(buttons1), 32'hA5);

      // A and Start pressed.
      pat4 = 8'h09;
      #2 rst4 = 1'b0;
      wait_for(W_LATCH4, 60, n);
      chk("idle_after_rst4", n, 20);
      wait_for(W_FV4, 120, n);
      chk("frame_len_a_start", n, 69);
      chk("buttons_a_start", 32'(buttons4), 32'h09);

      // Line held high, then held low.
      #2 force4 = 1'b1; lvl4 = 1'b1;
      wait_for(W_FV4, 150, n);
      chk("period_held_hi", n, 89);
      chk("buttons_held_hi", 32'(buttons4), 32'h00);
      #2 lvl4 = 1'b0;
      wait_for(W_FV4, 150, n);
      chk("period_held_lo", n, 89);
      chk("buttons_held_lo", 32'(buttons4), 32'hFF);

      // Pattern change in the middle of a frame.
      #2 force4 = 1'b0; pat4 = 8'h81;
      wait_for(W_FV4, 150, n);
      chk("buttons_pat81", 32'(buttons4), 32'h81);
      wait_for(W_LATCH4, 60, n);
      wait_for(W_LATCH4_FALL, 20, n);
      repeat (10) @(negedge clk);
      #2 pat4 = 8'h42;
      wait_for(W_FV4, 150, n);
      chk("buttons_mid_change", 32'(buttons4), 32'h81);
      wait_for(W_FV4, 150, n);
      chk("buttons_next_frame", 32'(buttons4), 32'h42);

      // Reset during the HIGH phase of bit 3.
      wait_for(W_LATCH4, 60, n);
      repeat (37) @(negedge clk);
      chk("in_high_bit3", 32'(nes_clk4), 32'd1);
      #2 rst4 = 1'b1;
      #1;
      chk("abort_latch", 32'(nes_latch4), 32'd0);
      chk("abort_nclk", 32'(nes_clk4), 32'd0);
      chk("abort_buttons", 32'(buttons4), 32'd0);
      chk("abort_fv", 32'(fv4), 32'd0);
      repeat (4) begin
         @(negedge clk);
         chk("abort_fv_hold", 32'(fv4), 32'd0);
      end
      #2 rst4 = 1'b0;
      wait_for(W_LATCH4, 60, n);
      chk("idle_after_abort", n, 20);
      wait_for(W_FV4, 120, n);
      chk("frame_len_after_abort", n, 69);
      chk("buttons_after_abort", 32'(buttons4), 32'h42);

      // Randomized frames; the monitors compare each one.
      for (int i = 0; i < 12; i++) begin
         #2;
         force4 = ($urandom_range(0, 4) == 0);
         lvl4   = 1'($urandom_range(0, 1));
         pat1   = 8'($urandom);
         repeat ($urandom_range(0, 80)) @(negedge clk);
         #2 pat4 = 8'($urandom);
         wait_for(W_FV4, 200, n);
      end

      chk("div1_frames_seen", 32'(frames1 >= 20), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
